// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider for DIV/DIVU in the execute stage
// Optional build macro: DIV_ZERO_FAST_EN (divide-by-zero skips the iterations and finishes in one cycle)
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] aE,
    input  logic [WIDTH-1:0] bE,
    input  logic             flush_exceptM,
    output logic             stall_divE,
    output logic             div_readyE,
    output logic [WIDTH-1:0] div_loE,
    output logic [WIDTH-1:0] div_hiE
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [5:0]         cnt;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quo;        // holds |dividend| bits, shifted out MSB first as quotient bits shift in
    logic [WIDTH:0]     rem;        // partial remainder, one bit wider than the operands
    logic [WIDTH-1:0]   a_raw;      // unmodified dividend, returned as remainder on divide-by-zero
    logic               q_neg;
    logic               r_neg;
    logic               dbz;
    logic               ready_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_r;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH+1:0]   trial;
    logic               q_bit;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   lo_fix;
    logic [WIDTH-1:0]   hi_fix;

    // Operand magnitudes, one restoring iteration, and sign correction of the final step
    always_comb begin
        a_neg    = signedE & aE[WIDTH-1];
        b_neg    = signedE & bE[WIDTH-1];
        a_abs    = a_neg ? -aE : aE;
        b_abs    = b_neg ? -bE : bE;
        trial    = {rem, quo[WIDTH-1]} - {2'b00, divisor};
        q_bit    = ~trial[WIDTH+1];
        rem_next = q_bit ? trial[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
        quo_next = {quo[WIDTH-2:0], q_bit};
        lo_fix   = q_neg ? -quo_next : quo_next;
        hi_fix   = r_neg ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    // Control FSM and datapath; flush abandons the operation from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            a_raw   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dbz     <= 1'b0;
            ready_r <= 1'b0;
            lo_r    <= '0;
            hi_r    <= '0;
        end else if (flush_exceptM) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (div_startE) begin
                        divisor <= b_abs;
                        quo     <= a_abs;
                        rem     <= '0;
                        a_raw   <= aE;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        dbz     <= (bE == '0);
                        cnt     <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (bE == '0) begin
                            state   <= DONE;
                            ready_r <= 1'b1;
                            lo_r    <= '1;
                            hi_r    <= aE;
                        end else begin
                            state   <= BUSY;
                        end
`else
                        state   <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    quo <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(WIDTH - 1)) begin
                        state   <= DONE;
                        ready_r <= 1'b1;
                        lo_r    <= dbz ? '1    : lo_fix;
                        hi_r    <= dbz ? a_raw : hi_fix;
                    end
                end
                DONE: begin
                    // The hazard unit lets E advance here, so the result is taken this cycle
                    state   <= IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign div_readyE = ready_r & ~flush_exceptM;
    assign stall_divE = div_startE & ~div_readyE & ~flush_exceptM;
    assign div_loE    = lo_r;
    assign div_hiE    = hi_r;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed DIV/DIVU vectors
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_startE;
    logic        signedE;
    logic [31:0] aE;
    logic [31:0] bE;
    logic        flush_exceptM;
    logic        stall_divE;
    logic        div_readyE;
    logic [31:0] div_loE;
    logic [31:0] div_hiE;

    div_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_startE    (div_startE),
        .signedE       (signedE),
        .aE            (aE),
        .bE            (bE),
        .flush_exceptM (flush_exceptM),
        .stall_divE    (stall_divE),
        .div_readyE    (div_readyE),
        .div_loE       (div_loE),
        .div_hiE       (div_hiE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every result the DUT presents is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && div_readyE === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: lo %h hi %h with no operation pending", div_loE, div_hiE);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient_lo", div_loE, mon_e.lo);
                chk("remainder_hi", div_hiE, mon_e.hi);
                chk("ready_latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
        end
    end

    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] elo, input logic [31:0] ehi,
                            input int elat, input bit push);
        exp_t e;
        signedE    = s;
        aE         = a;
        bE         = b;
        div_startE = 1'b1;
        if (push) begin
            e.lo  = elo;
            e.hi  = ehi;
            e.lat = elat;
            e.t0  = cyc;
            sb.push_back(e);
        end
    endtask

    // Called at the start-cycle negedge; returns just after the negedge where ready is seen
    task automatic wait_done(input int elat);
        int sc;
        bit got;
        sc  = 0;
        got = 1'b0;
        for (int n = 0; n < 80; n++) begin
            #1;
            if (stall_divE) sc++;
            if (div_readyE) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: no div_readyE within 80 cycles");
        end
        chk("stall_cycles", 32'(sc), 32'(elat));
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi, input int elat);
        start_op(s, a, b, elo, ehi, elat, 1'b1);
        wait_done(elat);
        div_startE = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sc;
        rst           = 1'b1;
        div_startE    = 1'b0;
        signedE       = 1'b0;
        aE            = '0;
        bE            = '0;
        flush_exceptM = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stall", 32'(stall_divE), 32'd0);
        chk("reset_ready", 32'(div_readyE), 32'd0);
        chk("reset_lo", div_loE, 32'd0);
        chk("reset_hi", div_hiE, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div(1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33);
        run_div(1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  33);
        run_div(1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         33);
        run_div(1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678,  ZLAT);
        run_div(1'b1, 32'hFFFFFFF8,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF8,  ZLAT);
        run_div(1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         33);
        run_div(1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         33);

        // Back-to-back: start held high, second operation begins at T34
        start_op(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33, 1'b1);
        wait_done(33);
        @(negedge clk);
        start_op(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 33, 1'b1);
        wait_done(33);
        div_startE = 1'b0;
        @(negedge clk);

        // Flush at T10 abandons the divide; a new one starts at T11
        start_op(1'b0, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, 0, 1'b0);
        repeat (10) @(negedge clk);
        flush_exceptM = 1'b1;
        #1;
        chk("flush_stall", 32'(stall_divE), 32'd0);
        chk("flush_ready", 32'(div_readyE), 32'd0);
        @(negedge clk);
        flush_exceptM = 1'b0;
        start_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b1);
        wait_done(33);
        div_startE = 1'b0;
        @(negedge clk);

        // Reset at T5 of a divide
        start_op(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst        = 1'b1;
        div_startE = 1'b0;
        @(negedge clk);
        #1;
        chk("midreset_stall", 32'(stall_divE), 32'd0);
        chk("midreset_ready", 32'(div_readyE), 32'd0);
        chk("midreset_lo", div_loE, 32'd0);
        chk("midreset_hi", div_hiE, 32'd0);
        rst = 1'b0;
        sc  = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (stall_divE) sc++;
        end
        chk("post_reset_stall_cycles", 32'(sc), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider in the execute stage of the MIPS pipeline. It serves DIV and DIVU, producing quotient (LO) and remainder (HI) for the HI/LO write path. While an operation is in flight it drives `stall_divE` to the hazard unit, which holds F/D/E. It abandons its work when an exception flush reaches memory stage.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `div_startE`  in  1  a DIV/DIVU instruction is valid in E. Held high until the result is taken.
- `signedE`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled together with the operands.
- `aE`  in  32  dividend, forwarded rs value.
- `bE`  in  32  divisor, forwarded rt value.
- `flush_exceptM`  in  1  exception flush; cancels any operation.
- `stall_divE`  out  1  hold the pipeline; goes to the hazard unit's `stall_divE`.
- `div_readyE`  out  1  result valid this cycle.
- `div_loE`  out  32  quotient.
- `div_hiE`  out  32  remainder.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `div_startE` is high and `flush_exceptM` is low:
    - latch |a| and |b| (absolute values only when `signedE`=1),
    - latch quotient sign = a[31]^b[31] and remainder sign = a[31] (signed only),
    - latch a divide-by-zero flag,
    - clear the 6-bit iteration counter, go to BUSY.
- **BUSY**
  - Restoring radix-2 division, one quotient bit per cycle, MSB first, using a 33-bit partial remainder.
  - After iteration 31 (counter = 31), go to DONE.
- **DONE**
  - `div_readyE`=1. Outputs are the sign-corrected quotient and remainder.
  - Next cycle goes unconditionally to IDLE; the hazard unit guarantees E advances on this cycle.
- `stall_divE` = `div_startE` & ~`div_readyE` & ~`flush_exceptM`. This is high in IDLE on the start cycle and throughout BUSY.
- Divide by zero (`bE`=0, either signedness):
  - `div_loE` = 0xFFFFFFFF, `div_hiE` = `aE` as latched, no sign correction.
  - No trap is raised.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: `div_loE` = 0x80000000, `div_hiE` = 0.
- Sign rules: remainder takes the dividend's sign; |remainder| < |divisor|.
- `flush_exceptM` has priority over everything:
  - in any state, next state is IDLE and the counter clears,
  - `stall_divE`=0 and `div_readyE`=0 in that cycle.
- `rst`: state IDLE, counter 0, all datapath registers 0.
  - Reset outputs: `stall_divE`=0, `div_readyE`=0, `div_loE`=0, `div_hiE`=0.
- Outside DONE, `div_loE` and `div_hiE` hold their last values and must not be used.

## Timing
- Start cycle is T0 (IDLE with `div_startE`=1). BUSY covers T1..T32. DONE is T33.
- `stall_divE` is high T0..T32 (33 cycles) and low at T33.
- `div_readyE` is high at T33 only.
- Divide-by-zero latency depends on configuration (see below).
- Back-to-back divides: the second start is seen at T34 in IDLE. There is no overlap.
- `div_startE` dropping during BUSY (a bubble injected by flush) without `flush_exceptM`:
  - the operation completes,
  - the result is discarded,
  - `stall_divE` stays 0.
- `rst` mid-operation: IDLE on the next edge, no result produced.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - divisor = 0 goes IDLE→DONE directly, giving result at T1,
  - `stall_divE` is high only at T0.
- Undefined: divisor = 0 runs the full 32 iterations, then DONE overrides the outputs with the divide-by-zero values.
- Result values are identical either way; only latency differs.

## Test plan
- DIVU 100/7 at T0 → `stall_divE` high T0..T32; at T33 `div_readyE`=1, LO=14, HI=2.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0:
  - with `DIV_ZERO_FAST_EN`: ready at T1,
  - without: ready at T33,
  - both: LO=0xFFFFFFFF, HI=0x12345678.
- DIVU 0xFFFFFFFF/3 with `flush_exceptM` pulsed at T10:
  - `stall_divE`=0 at T10, IDLE at T11, no `div_readyE`,
  - a new DIVU 9/3 started at T11 gives LO=3, HI=0 at T44.
- `rst` asserted at T5 of a divide → all outputs 0 at T6, `stall_divE` stays 0 with `div_startE` low.
